output_grant_scheduler: RTL

Per-output-port grant scheduler for the priority crossbar. It sits between the virtual priority queue request vectors and the input-side accept logic. Each cycle it picks the highest-priority requesting input by round-robin and offers a one-cycle grant. On accept it locks the output for one frame transfer, then returns to arbitration. One instance per output port; iSLIP pointer rule: a pointer advances only on accept.

---
 rtl/output_grant_scheduler_pkg.sv | 30 +++
 rtl/output_grant_scheduler_sel.sv | 39 +++
 rtl/output_grant_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/output_grant_scheduler_pkg.sv
// Shared types and helpers for the per-output grant scheduler.
// Holds the FSM state encoding, a width helper and a one-hot builder.
package output_grant_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2
  } state_e;

  localparam int ONEHOT_MAX = 64;

  // Ceiling log2 that never returns less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      w = ((32'sd1 <<< i) < value) ? i + 1 : w;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [ONEHOT_MAX-1:0] onehot(input int idx);
    logic [ONEHOT_MAX-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/output_grant_scheduler_sel.sv
// Combinational round-robin selector: lowest requesting priority level,
// then first requesting input at or after that level's pointer.
module rr_pri_select
  import output_grant_scheduler_pkg::*;
#(
  parameter int N     = 8,
  parameter int P     = 4,
  parameter int PTR_W = clog2_min1(N),
  parameter int PRI_W = clog2_min1(P)
) (
  input  logic [N*P-1:0]     req,
  input  logic [P*PTR_W-1:0] ptr,
  output logic               valid,
  output logic [PTR_W-1:0]   idx,
  output logic [PRI_W-1:0]   pri
);

  int   cand_s;
  logic hit_s;

  // Scan from the least preferred candidate to the most preferred so the winner is written last.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    pri    = '0;
    cand_s = 0;
    hit_s  = 1'b0;
    for (int p = P - 1; p >= 0; p--) begin
      for (int k = N - 1; k >= 0; k--) begin
        cand_s = (int'(ptr[p*PTR_W +: PTR_W]) + k) % N;
        hit_s  = req[cand_s*P + p];
        valid  = valid | hit_s;
        idx    = hit_s ? PTR_W'(cand_s) : idx;
        pri    = hit_s ? PRI_W'(p) : pri;
      end
    end
  end

endmodule

// File: rtl/output_grant_scheduler.sv
// Per-output grant scheduler: offers a one-cycle grant, locks the output for
// a frame on accept, and advances the granted level's pointer only on accept.
module output_grant_scheduler
  import output_grant_scheduler_pkg::*;
#(
  parameter int N            = 8,
  parameter int P            = 4,
  parameter int FRAME_CYCLES = 8,
  parameter int WIDTH        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N*P-1:0]   i_req,
  input  logic [N-1:0]     i_accept,
  output logic [N-1:0]     o_grant,
  output logic [P-1:0]     o_grant_pri,
  output logic [N-1:0]     o_conn,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_xfer_cnt
);

  localparam int PTR_W = clog2_min1(N);
  localparam int PRI_W = clog2_min1(P);
  localparam int FC_W  = clog2_min1(FRAME_CYCLES);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_CYCLES - 1);

  state_e             state_r, state_s;
  logic [PTR_W-1:0]   ptr_r [P];
  logic [PTR_W-1:0]   ptr_s [P];
  logic [P*PTR_W-1:0] ptr_flat_s;
  logic [PTR_W-1:0]   gi_r, gi_s;
  logic [PRI_W-1:0]   gl_r, gl_s;
  logic [N-1:0]       grant_r, grant_s;
  logic [N-1:0]       conn_r, conn_s;
  logic [P-1:0]       pri_r, pri_s;
  logic               busy_r, busy_s;
  logic [WIDTH-1:0]   cnt_r, cnt_s;
  logic [FC_W-1:0]    fc_r, fc_s;
  logic               sel_valid_s;
  logic [PTR_W-1:0]   sel_idx_s;
  logic [PRI_W-1:0]   sel_pri_s;

  // Flatten the per-level pointers for the selector.
  always_comb begin
    ptr_flat_s = '0;
    for (int p = 0; p < P; p++) begin
      ptr_flat_s[p*PTR_W +: PTR_W] = ptr_r[p];
    end
  end

  rr_pri_select #(
    .N     (N),
    .P     (P),
    .PTR_W (PTR_W),
    .PRI_W (PRI_W)
  ) u_sel (
    .req   (i_req),
    .ptr   (ptr_flat_s),
    .valid (sel_valid_s),
    .idx   (sel_idx_s),
    .pri   (sel_pri_s)
  );

  // Next-state and next-output logic; requests only matter in IDLE.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    gi_s    = gi_r;
    gl_s    = gl_r;
    grant_s = grant_r;
    pri_s   = pri_r;
    conn_s  = conn_r;
    busy_s  = busy_r;
    cnt_s   = cnt_r;
    fc_s    = fc_r;
    case (state_r)
      ST_IDLE: begin
        if (sel_valid_s) begin
          state_s = ST_GRANT;
          grant_s = N'(onehot(int'(sel_idx_s)));
          pri_s   = P'(onehot(int'(sel_pri_s)));
          gi_s    = sel_idx_s;
          gl_s    = sel_pri_s;
          busy_s  = 1'b1;
        end else begin
          grant_s = '0;
          pri_s   = '0;
          conn_s  = '0;
          busy_s  = 1'b0;
        end
      end
      ST_GRANT: begin
        grant_s = '0;
        if (i_accept[gi_r]) begin
          state_s     = ST_XFER;
          ptr_s[gl_r] = (int'(gi_r) == N - 1) ? '0 : gi_r + PTR_W'(1);
          cnt_s       = (&cnt_r) ? cnt_r : cnt_r + WIDTH'(1);
          conn_s      = N'(onehot(int'(gi_r)));
          fc_s        = FC_LAST;
          busy_s      = 1'b1;
        end else begin
          state_s = ST_IDLE;
          pri_s   = '0;
          busy_s  = 1'b0;
        end
      end
      ST_XFER: begin
        if (fc_r == '0) begin
          state_s = ST_IDLE;
          conn_s  = '0;
          pri_s   = '0;
          busy_s  = 1'b0;
        end else begin
          fc_s = fc_r - FC_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = '0;
        pri_s   = '0;
        conn_s  = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, pointers and all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      for (int p = 0; p < P; p++) begin
        ptr_r[p] <= '0;
      end
      gi_r    <= '0;
      gl_r    <= '0;
      grant_r <= '0;
      pri_r   <= '0;
      conn_r  <= '0;
      busy_r  <= 1'b0;
      cnt_r   <= '0;
      fc_r    <= '0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      gi_r    <= gi_s;
      gl_r    <= gl_s;
      grant_r <= grant_s;
      pri_r   <= pri_s;
      conn_r  <= conn_s;
      busy_r  <= busy_s;
      cnt_r   <= cnt_s;
      fc_r    <= fc_s;
    end
  end

  assign o_grant     = grant_r;
  assign o_grant_pri = pri_r;
  assign o_conn      = conn_r;
  assign o_busy      = busy_r;
  assign o_xfer_cnt  = cnt_r;

endmodule
